rv_reg_slice: RTL



---
 rtl/rv_reg_slice.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/rv_reg_slice.sv
// Ready/valid register slice, STAGES cascaded stages of one timing MODE, with occupancy count.
// Optional synchronous flush port when RV_REG_SLICE_FLUSH_EN is defined.

module rv_reg_slice_stage #(
  parameter int WIDTH = 8,
  parameter int MODE  = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             m_valid,
  input  logic [WIDTH-1:0] m_data,
  output logic             m_ready,
  output logic             s_valid,
  output logic [WIDTH-1:0] s_data,
  input  logic             s_ready,
  output logic [1:0]       cnt
);

  if (MODE == 0) begin : g_bypass
    logic unused_clk;
    assign unused_clk = clk ^ rst_n;
    assign s_valid = m_valid & ~flush;
    assign s_data  = m_data;
    assign m_ready = s_ready & ~flush;
    assign cnt     = '0;

  end else if (MODE == 1) begin : g_fwd
    logic             v;
    logic [WIDTH-1:0] d;
    // Ready is combinational: a full register may refill on the same edge it drains.
    assign m_ready = (~v | s_ready) & ~flush;
    assign s_valid = v & ~flush;
    assign s_data  = d;
    assign cnt     = {1'b0, v};

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v <= 1'b0;
        d <= '0;
      end else if (flush) begin
        v <= 1'b0;
      end else if (m_valid && m_ready) begin
        v <= 1'b1;
        d <= m_data;
      end else if (s_ready) begin
        v <= 1'b0;
      end
    end

  end else if (MODE == 2) begin : g_skid
    logic             sv;
    logic [WIDTH-1:0] sd;
    assign m_ready = ~sv & ~flush;
    assign s_valid = (sv | m_valid) & ~flush;
    assign s_data  = sv ? sd : m_data;
    assign cnt     = {1'b0, sv};

    // The skid only captures a beat that was accepted but could not pass straight through.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sv <= 1'b0;
        sd <= '0;
      end else if (flush) begin
        sv <= 1'b0;
      end else if (m_valid && m_ready && !s_ready) begin
        sv <= 1'b1;
        sd <= m_data;
      end else if (sv && s_ready) begin
        sv <= 1'b0;
      end
    end

  end else begin : g_full
    logic [1:0]       c;
    logic [WIDTH-1:0] head, tail;
    logic             push, pop;
    assign m_ready = (c != 2'd2) & ~flush;
    assign s_valid = (c != 2'd0) & ~flush;
    assign s_data  = head;
    assign cnt     = c;
    assign push    = m_valid & m_ready;
    assign pop     = s_valid & s_ready;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        c    <= 2'd0;
        head <= '0;
        tail <= '0;
      end else if (flush) begin
        c <= 2'd0;
      end else begin
        case ({push, pop})
          2'b10: begin
            if (c == 2'd0) head <= m_data;
            else           tail <= m_data;
            c <= c + 2'd1;
          end
          2'b01: begin
            head <= tail;
            c    <= c - 2'd1;
          end
          2'b11: begin
            // At one entry the new beat replaces the departing head directly.
            if (c == 2'd1) head <= m_data;
            else begin
              head <= tail;
              tail <= m_data;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

module rv_reg_slice #(
  parameter int WIDTH  = 8,
  parameter int MODE   = 3,
  parameter int STAGES = 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              m_valid,
  input  logic [WIDTH-1:0]                  m_data,
  output logic                              m_ready,
  output logic                              s_valid,
  output logic [WIDTH-1:0]                  s_data,
  input  logic                              s_ready,
  output logic [$clog2(2*STAGES+1)-1:0]     occupancy
`ifdef RV_REG_SLICE_FLUSH_EN
  ,
  input  logic                              flush
`endif
);

  localparam int OW      = $clog2(2*STAGES+1);
  localparam int OCC_MAX = (MODE == 0) ? 0 : (MODE == 3) ? 2*STAGES : STAGES;

  if (MODE < 0 || MODE > 3 || STAGES < 1 || STAGES > 8) begin : g_bad_cfg
    $error("rv_reg_slice: unsupported MODE=%0d / STAGES=%0d", MODE, STAGES);
  end

`ifndef RV_REG_SLICE_FLUSH_EN
  logic flush;
  assign flush = 1'b0;
`endif

  logic [STAGES-1:0][1:0] stage_cnt;

  // Each stage keeps its own link signals so the forward valid and backward ready chains stay acyclic.
  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    logic             in_v, in_r, out_v, out_r;
    logic [WIDTH-1:0] in_d, out_d;

    if (k == 0) begin : g_first
      assign in_v = m_valid;
      assign in_d = m_data;
    end else begin : g_link
      assign in_v = g_stg[k-1].out_v;
      assign in_d = g_stg[k-1].out_d;
    end

    if (k == STAGES-1) begin : g_last
      assign out_r = s_ready;
    end else begin : g_next
      assign out_r = g_stg[k+1].in_r;
    end

    rv_reg_slice_stage #(.WIDTH(WIDTH), .MODE(MODE)) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush   (flush),
      .m_valid (in_v),
      .m_data  (in_d),
      .m_ready (in_r),
      .s_valid (out_v),
      .s_data  (out_d),
      .s_ready (out_r),
      .cnt     (stage_cnt[k])
    );
  end

  assign m_ready = g_stg[0].in_r;
  assign s_valid = g_stg[STAGES-1].out_v;
  assign s_data  = g_stg[STAGES-1].out_d;

  always_comb begin
    occupancy = '0;
    for (int k = 0; k < STAGES; k++) occupancy = occupancy + OW'(stage_cnt[k]);
  end

  if (MODE != 0) begin : g_chk
    a_hold: assert property (@(posedge clk) disable iff (!rst_n)
      s_valid && !s_ready |=> flush || (s_valid && $stable(s_data)));
  end
  a_occ: assert property (@(posedge clk) disable iff (!rst_n) occupancy <= OW'(OCC_MAX));

endmodule
